// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: registered FSM stepping each instruction through
// fetch/decode/execute/memory/write-back, with memory stalls and a retire counter.
module multicycle_controller #(
  parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        Retire,
  output logic        IllegalOp,
  output logic [31:0] InstrCount,
  output logic [3:0]  State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  state_t state, next_state;
  logic   is_store;

  // lw/sw choice is captured in DECODE so later Opcode changes cannot redirect MEMADR.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_FETCH;
      InstrCount <= '0;
      is_store   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        is_store <= (Opcode == OP_SW);
      if (Retire)
        InstrCount <= InstrCount + 32'd1;
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    Retire     = 1'b0;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default: begin
            IllegalOp  = 1'b1;
            next_state = ILLEGAL_TO_FETCH ? S_FETCH : S_HALT;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Retire   = MemReady;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        PCWrite    = Zero;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase

    // Reset masks every strobe so an aborted instruction writes nothing.
    if (Rst) begin
      PCWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      PCSource  = 2'b00;
      Retire    = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: per-cycle state, control
// word and retire count against hand-computed vectors, plus HALT and wrap sequences.
module tb_multicycle_controller;

  logic        clk;
  logic        rst, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, retire, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] instr_count;
  logic [3:0]  state;

  logic        h_rst;
  logic [5:0]  h_opcode;
  logic        h_pc_write, h_iord, h_mem_read, h_mem_write, h_ir_write, h_reg_dst, h_mem_to_reg;
  logic        h_reg_write, h_alu_src_a, h_retire, h_illegal_op;
  logic [1:0]  h_alu_src_b, h_alu_op, h_pc_source;
  logic [31:0] h_instr_count;
  logic [3:0]  h_state;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .Clk(clk), .Rst(rst), .Opcode(opcode), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pc_write), .IorD(iord), .MemRead(mem_read), .MemWrite(mem_write),
    .IRWrite(ir_write), .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op), .PCSource(pc_source),
    .Retire(retire), .IllegalOp(illegal_op), .InstrCount(instr_count), .State(state)
  );

  multicycle_controller #(.ILLEGAL_TO_FETCH(1'b0)) dut_h (
    .Clk(clk), .Rst(h_rst), .Opcode(h_opcode), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(h_pc_write), .IorD(h_iord), .MemRead(h_mem_read), .MemWrite(h_mem_write),
    .IRWrite(h_ir_write), .RegDst(h_reg_dst), .MemtoReg(h_mem_to_reg), .RegWrite(h_reg_write),
    .ALUSrcA(h_alu_src_a), .ALUSrcB(h_alu_src_b), .ALUOp(h_alu_op), .PCSource(h_pc_source),
    .Retire(h_retire), .IllegalOp(h_illegal_op), .InstrCount(h_instr_count), .State(h_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {PCWrite,IorD,MemRead,MemWrite,IRWrite, RegDst,MemtoReg,RegWrite,ALUSrcA,
  //                ALUSrcB, ALUOp, PCSource, Retire,IllegalOp}
  localparam logic [16:0] C_NONE   = 17'b00000_0000_00_00_00_00;
  localparam logic [16:0] C_FETCH1 = 17'b10101_0000_01_00_00_00;
  localparam logic [16:0] C_FETCH0 = 17'b00100_0000_01_00_00_00;
  localparam logic [16:0] C_DEC    = 17'b00000_0000_11_00_00_00;
  localparam logic [16:0] C_DECILL = 17'b00000_0000_11_00_00_01;
  localparam logic [16:0] C_ADR    = 17'b00000_0001_10_00_00_00;
  localparam logic [16:0] C_MEMRD  = 17'b01100_0000_00_00_00_00;
  localparam logic [16:0] C_MEMWB  = 17'b00000_0110_00_00_00_10;
  localparam logic [16:0] C_MEMWR0 = 17'b01010_0000_00_00_00_00;
  localparam logic [16:0] C_MEMWR1 = 17'b01010_0000_00_00_00_10;
  localparam logic [16:0] C_EXEC   = 17'b00000_0001_00_10_00_00;
  localparam logic [16:0] C_ALUWB  = 17'b00000_1010_00_00_00_10;
  localparam logic [16:0] C_ADDIWB = 17'b00000_0010_00_00_00_10;
  localparam logic [16:0] C_BR1    = 17'b10000_0001_00_01_01_10;
  localparam logic [16:0] C_BR0    = 17'b00000_0001_00_01_01_10;
  localparam logic [16:0] C_JUMP   = 17'b10000_0000_00_00_10_10;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, IL = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] ctl_main();
    return {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_source, retire, illegal_op};
  endfunction

  function automatic logic [16:0] ctl_halt();
    return {h_pc_write, h_iord, h_mem_read, h_mem_write, h_ir_write, h_reg_dst, h_mem_to_reg,
            h_reg_write, h_alu_src_a, h_alu_src_b, h_alu_op, h_pc_source, h_retire, h_illegal_op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input logic [3:0] s, input logic [16:0] c, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.op = o; v.z = z; v.mr = m; v.st = s; v.ctl = c; v.cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset state, then R-type
    add(1, RT, 0, 1, 0,  C_NONE,   0);
    add(0, RT, 0, 1, 0,  C_FETCH1, 0);
    add(0, RT, 0, 1, 1,  C_DEC,    0);
    add(0, LW, 1, 1, 6,  C_EXEC,   0);
    add(0, SW, 1, 1, 7,  C_ALUWB,  0);
    // lw with two stall cycles in MEMRD
    add(0, LW, 0, 1, 0,  C_FETCH1, 1);
    add(0, LW, 0, 1, 1,  C_DEC,    1);
    add(0, LW, 0, 1, 2,  C_ADR,    1);
    add(0, LW, 0, 0, 3,  C_MEMRD,  1);
    add(0, LW, 0, 0, 3,  C_MEMRD,  1);
    add(0, LW, 0, 1, 3,  C_MEMRD,  1);
    add(0, LW, 0, 1, 4,  C_MEMWB,  1);
    // beq taken, then not taken
    add(0, BQ, 1, 1, 0,  C_FETCH1, 2);
    add(0, BQ, 1, 1, 1,  C_DEC,    2);
    add(0, BQ, 1, 1, 8,  C_BR1,    2);
    add(0, BQ, 0, 1, 0,  C_FETCH1, 3);
    add(0, BQ, 0, 1, 1,  C_DEC,    3);
    add(0, BQ, 0, 1, 8,  C_BR0,    3);
    // sw: stall in FETCH and MEMWR; opcode changes after DECODE are ignored
    add(0, SW, 0, 0, 0,  C_FETCH0, 4);
    add(0, SW, 0, 1, 0,  C_FETCH1, 4);
    add(0, SW, 0, 1, 1,  C_DEC,    4);
    add(0, LW, 0, 1, 2,  C_ADR,    4);
    add(0, LW, 0, 0, 5,  C_MEMWR0, 4);
    add(0, LW, 0, 1, 5,  C_MEMWR1, 4);
    // addi
    add(0, AI, 0, 1, 0,  C_FETCH1, 5);
    add(0, AI, 0, 1, 1,  C_DEC,    5);
    add(0, AI, 0, 1, 10, C_ADR,    5);
    add(0, AI, 0, 1, 11, C_ADDIWB, 5);
    // j
    add(0, JJ, 0, 1, 0,  C_FETCH1, 6);
    add(0, JJ, 0, 1, 1,  C_DEC,    6);
    add(0, JJ, 0, 1, 9,  C_JUMP,   6);
    // illegal opcode returns to FETCH without retiring
    add(0, IL, 0, 1, 0,  C_FETCH1, 7);
    add(0, IL, 0, 1, 1,  C_DECILL, 7);
    add(0, SW, 0, 1, 0,  C_FETCH1, 7);
    // reset in the middle of a stalled store
    add(0, SW, 0, 1, 1,  C_DEC,    7);
    add(0, SW, 0, 1, 2,  C_ADR,    7);
    add(0, SW, 0, 0, 5,  C_MEMWR0, 7);
    add(1, SW, 0, 0, 5,  C_NONE,   7);
    add(0, SW, 0, 0, 0,  C_FETCH0, 0);

    rst = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b1;
    h_rst = 1'b1; h_opcode = RT;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
      #1;
      check($sformatf("state[%0d]", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("ctl[%0d]", i), {15'd0, ctl_main()}, {15'd0, vecs[i].ctl});
      check($sformatf("count[%0d]", i), instr_count, vecs[i].cnt);
      @(negedge clk);
    end

    // Count wrap: preload near the top, then two jumps
    mem_ready = 1'b1; opcode = JJ; zero = 1'b0;
    force dut.InstrCount = 32'hFFFF_FFFE;
    #1;
    release dut.InstrCount;
    #1;
    check("wrap_preload", instr_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        if (c == 2) check($sformatf("wrap_jump_state[%0d]", k), {28'd0, state}, 32'd9);
        @(negedge clk);
      end
    end
    #1;
    check("wrap_state_fetch", {28'd0, state}, 32'd0);
    check("wrap_count", instr_count, 32'd0);

    // ILLEGAL_TO_FETCH = 0: unknown opcode locks in HALT until reset
    h_rst = 1'b0; h_opcode = IL; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("halt_decode_state", {28'd0, h_state}, 32'd1);
    check("halt_illegal_pulse", {15'd0, ctl_halt()}, {15'd0, C_DECILL});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      h_opcode = (c % 2 == 0) ? RT : JJ;
      #1;
      check($sformatf("halt_hold_state[%0d]", c), {28'd0, h_state}, 32'd15);
      check($sformatf("halt_hold_ctl[%0d]", c), {15'd0, ctl_halt()}, {15'd0, C_NONE});
    end
    check("halt_count", h_instr_count, 32'd0);
    h_rst = 1'b1;
    @(negedge clk);
    h_rst = 1'b0; #1;
    check("halt_exit_state", {28'd0, h_state}, 32'd0);
    check("halt_exit_ctl", {15'd0, ctl_halt()}, {15'd0, C_FETCH1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
